// File: rtl/x_mem_bridge.sv
// x_mem_bridge: word-addressed memory slave for the x_top_rv32i core.
// Serves requests from on-chip RAM, a UART TX data port backed by a byte
// FIFO, and a UART status register. Unmapped requests complete with zero data.
module x_mem_bridge #(
    parameter int RAM_WORDS    = 1024,
    parameter     INIT_FILE    = "",
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_rnw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_accept,
    output logic [31:0] o_data,
    output logic        o_tx
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(CLKS_PER_BIT);

    localparam logic [31:0] UART_DATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h8000_0004;

    typedef enum logic {
        REQ_IDLE,
        REQ_ACK
    } req_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Address decode (byte offset bits are masked off)
    // ------------------------------------------------------------------
    logic [31:0]       addr_w;
    logic              hit_ram;
    logic              hit_udata;
    logic              hit_ustat;
    logic [RAM_AW-1:0] ram_idx;

    assign addr_w    = i_addr & 32'hFFFF_FFFC;
    assign hit_ram   = ~addr_w[31] && ({3'b000, addr_w[30:2]} < 32'(RAM_WORDS));
    assign hit_udata = (addr_w == UART_DATA_ADDR);
    assign hit_ustat = (addr_w == UART_STAT_ADDR);
    assign ram_idx   = addr_w[RAM_AW+1:2];

    // ------------------------------------------------------------------
    // Shared state
    // ------------------------------------------------------------------
    req_state_t       req_state, req_next;
    tx_state_t        tx_state, tx_next;

    logic [31:0]      ram [RAM_WORDS];
    logic [31:0]      ram_q;
    logic             ram_we;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [FAW:0]     wr_ptr, rd_ptr;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    logic [CW-1:0]    clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             tx_busy;
    logic [31:0]      status;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FAW] != rd_ptr[FAW]) &&
                        (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);
    assign tx_busy    = (tx_state != TX_IDLE);
    assign status     = {29'b0, tx_busy, fifo_empty, fifo_full};
    assign bit_end    = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    // Request state register
    always_ff @(posedge i_clk) begin
        if (i_rst) req_state <= REQ_IDLE;
        else       req_state <= req_next;
    end

    // Request next-state, handshake and read-data mux
    always_comb begin
        req_next = req_state;
        o_accept = 1'b0;
        o_data   = '0;
        ram_we   = 1'b0;
        push     = 1'b0;
        case (req_state)
            REQ_IDLE: begin
                if (i_valid && !(hit_udata && !i_rnw && fifo_full))
                    req_next = REQ_ACK;
            end
            REQ_ACK: begin
                req_next = REQ_IDLE;
                o_accept = i_valid;
                if (i_valid && i_rnw) begin
                    if (hit_ram)        o_data = ram_q;
                    else if (hit_ustat) o_data = status;
                end
                ram_we = i_valid && !i_rnw && hit_ram;
                push   = i_valid && !i_rnw && hit_udata;
            end
            default: req_next = REQ_IDLE;
        endcase
    end

    // RAM: write on the edge ending ACK, read launched every IDLE cycle
    always_ff @(posedge i_clk) begin
        if (ram_we) ram[ram_idx] <= i_data;
        if (req_state == REQ_IDLE) ram_q <= ram[ram_idx];
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // FIFO pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (FAW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FAW+1)'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr[FAW-1:0]] <= i_data[7:0];
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    // TX state, bit timing and shift register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE || bit_end) clk_cnt <= '0;
            else                                clk_cnt <= clk_cnt + CW'(1);
            if (tx_state == TX_DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
            else if (tx_state == TX_IDLE)       bit_cnt <= '0;
            if (pop)                                  shreg <= fifo_mem[rd_ptr[FAW-1:0]];
            else if (tx_state == TX_DATA && bit_end) shreg <= {1'b1, shreg[7:1]};
        end
    end

    // TX next-state, FIFO pop and line level; the STOP->START shortcut keeps
    // queued frames back-to-back with no idle cycle between them
    always_comb begin
        tx_next = tx_state;
        pop     = 1'b0;
        o_tx    = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: begin
                o_tx = 1'b0;
                if (bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                o_tx = shreg[0];
                if (bit_end && bit_cnt == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        tx_next = TX_START;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_x_mem_bridge.sv
// Self-checking bench for x_mem_bridge: RAM, UART TX path, status, unmapped
// accesses, FIFO back-pressure and reset mid-frame, against a cycle-level
// reference model of request latency, FIFO occupancy and frame timing.
module tb_x_mem_bridge;

    localparam int RW    = 64;
    localparam int FD    = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int HIST  = 16384;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_rnw;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_accept;
    logic [31:0] o_data;
    logic        o_tx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic tx_hist [HIST];

    // reference model state
    logic [31:0] ram_m [int];
    int          m_ack [$];
    int          m_pop [$];
    logic [7:0]  m_byte [$];

    x_mem_bridge #(
        .RAM_WORDS   (RW),
        .INIT_FILE   (""),
        .FIFO_DEPTH  (FD),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_rnw   (i_rnw),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .o_accept(o_accept),
        .o_data  (o_data),
        .o_tx    (o_tx)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    // Cycle index: cycle k runs between rising edges k and k+1
    always @(posedge i_clk) cyc <= cyc + 1;

    // Record the serial line once per cycle, mid-cycle
    always @(negedge i_clk) if (cyc < HIST) tx_hist[cyc] = o_tx;

    // ---------------- reference model helpers ----------------
    // FIFO level as seen by registered logic during cycle t
    function automatic int level_at(int t);
        int n = 0;
        foreach (m_ack[i]) begin
            if (m_ack[i] < t) n++;
            if (m_pop[i] < t) n--;
        end
        return n;
    endfunction

    // Transmitter busy during cycle t: a frame occupies pop+1 .. pop+FRAME
    function automatic logic busy_at(int t);
        foreach (m_pop[i])
            if (t >= m_pop[i] + 1 && t <= m_pop[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    // Byte pushed at the end of cycle ack leaves the FIFO when the line is free
    function automatic int next_pop(int ack);
        if (m_pop.size() == 0) return ack + 1;
        return (ack + 1 > m_pop[$] + FRAME) ? ack + 1 : m_pop[$] + FRAME;
    endfunction

    function automatic logic [31:0] status_at(int t);
        int lv = level_at(t);
        return {29'b0, busy_at(t), lv == 0, lv == FD};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // One request; returns read data and the cycle of acceptance
    task automatic req(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rd, output int ack);
        i_valid = 1'b1;
        i_rnw   = rnw;
        i_addr  = addr;
        i_data  = data;
        ack     = -1;
        rd      = '0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge i_clk);
            #1;
            if (o_accept) begin
                ack = cyc;
                rd  = o_data;
                break;
            end
        end
        if (ack < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_timeout addr=%h: no accept within 2000 cycles", addr);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_rnw   = 1'b1;
        i_addr  = '0;
        i_data  = '0;
    endtask

    // UART data write; returns the model's acceptance cycle and the observed one
    task automatic uart_write(input logic [7:0] b, output int exp_ack, output int ack);
        int          t = cyc;
        int          p;
        logic [31:0] rd;
        while (level_at(t) >= FD) t++;
        exp_ack = t + 1;
        req(1'b0, 32'h8000_0000, {24'($urandom), b}, rd, ack);
        p = next_pop(exp_ack);
        m_ack.push_back(exp_ack);
        m_pop.push_back(p);
        m_byte.push_back(b);
    endtask

    task automatic wait_uart_done();
        int end_t = (m_pop.size() != 0) ? m_pop[$] + FRAME + 2 : cyc;
        while (cyc < end_t) idle(1);
    endtask

    task automatic clear_model();
        m_ack.delete();
        m_pop.delete();
        m_byte.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        int          ack, r;
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_rnw = 1'b1;
        i_addr = '0;
        i_data = '0;
        idle(4);
        i_rst = 1'b0;
        n_cmp++;
        if (o_accept !== 1'b0) begin
            n_err++;
            $display("FAIL reset_accept got=%b want=0", o_accept);
        end
        n_cmp++;
        if (o_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got=%h want=00000000", o_data);
        end
        n_cmp++;
        if (o_tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx got=%b want=1", o_tx);
        end
        r = cyc;
        req(1'b1, 32'h8000_0004, '0, rd, ack);
        n_cmp++;
        if (rd !== 32'h0000_0002 || ack != r + 1) begin
            n_err++;
            $display("FAIL reset_status got=%h@%0d want=00000002@%0d", rd, ack, r + 1);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] rd;
        int          ack, r;
        req(1'b0, 32'h0000_0000, 32'h0000_0013, rd, ack);
        ram_m[0] = 32'h0000_0013;
        r = cyc;
        req(1'b1, 32'h0000_0000, '0, rd, ack);
        n_cmp++;
        if (ack != r + 1 || rd !== 32'h0000_0013) begin
            n_err++;
            $display("FAIL fetch got=%h@+%0d want=00000013@+1", rd, ack - r);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, rd2;
        int          ack, ack2, r;
        req(1'b0, 32'h0000_0014, 32'h1234_5678, rd, ack);
        ram_m[5] = 32'h1234_5678;
        req(1'b0, 32'h0000_0010, 32'hCAFE_F00D, rd, ack);
        ram_m[4] = 32'hCAFE_F00D;
        // load then fetch, back to back: 4 cycles in total
        r = cyc;
        req(1'b1, 32'h0000_0010, '0, rd, ack);
        req(1'b1, 32'h0000_0014, '0, rd2, ack2);
        n_cmp++;
        if (rd !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL store_load got=%h want=cafef00d", rd);
        end
        n_cmp++;
        if (rd2 !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL neighbour_word got=%h want=12345678", rd2);
        end
        n_cmp++;
        if (ack != r + 1 || ack2 != r + 3 || cyc != r + 4) begin
            n_err++;
            $display("FAIL back_to_back acks=+%0d,+%0d end=+%0d want=+1,+3,+4",
                     ack - r, ack2 - r, cyc - r);
        end
        // last RAM word, and the first word past the RAM must not alias word 0
        req(1'b0, 32'h0000_00FF, 32'hA5A5_0F0F, rd, ack);
        ram_m[RW - 1] = 32'hA5A5_0F0F;
        req(1'b0, 32'h0000_0100, 32'hDEAD_BEEF, rd, ack);
        req(1'b1, 32'h0000_00FC, '0, rd, ack);
        n_cmp++;
        if (rd !== 32'hA5A5_0F0F) begin
            n_err++;
            $display("FAIL last_word got=%h want=a5a50f0f", rd);
        end
        req(1'b1, 32'h0000_0100, '0, rd, ack);
        req(1'b1, 32'h0000_0000, '0, rd2, ack2);
        n_cmp++;
        if (rd !== 32'h0 || rd2 !== ram_m[0]) begin
            n_err++;
            $display("FAIL past_end got=%h word0=%h want=00000000 word0=%h", rd, rd2, ram_m[0]);
        end
    endtask

    task automatic test_ram_random();
        logic [31:0] rd, d;
        int          ack, r, idx;
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, RW - 1));
            r   = cyc;
            if ($urandom_range(0, 1) == 0 || !ram_m.exists(idx)) begin
                d = $urandom;
                req(1'b0, 32'(idx) << 2 | 32'($urandom_range(0, 3)), d, rd, ack);
                ram_m[idx] = d;
                n_cmp++;
                if (ack != r + 1 || rd !== 32'h0) begin
                    n_err++;
                    $display("FAIL ram_wr[%0d] data=%h@+%0d want=00000000@+1", idx, rd, ack - r);
                end
            end else begin
                req(1'b1, 32'(idx) << 2, '0, rd, ack);
                n_cmp++;
                if (ack != r + 1 || rd !== ram_m[idx]) begin
                    n_err++;
                    $display("FAIL ram_rd[%0d] got=%h@+%0d want=%h@+1", idx, rd, ack - r, ram_m[idx]);
                end
            end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, a;
        int          ack, r;
        r = cyc;
        req(1'b1, 32'h4000_0000, '0, rd, ack);
        n_cmp++;
        if (ack != r + 1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_read got=%h@+%0d want=00000000@+1", rd, ack - r);
        end
        r = cyc;
        req(1'b0, 32'h8000_0008, 32'h0000_0077, rd, ack);
        n_cmp++;
        if (ack != r + 1) begin
            n_err++;
            $display("FAIL unmapped_write accept=+%0d want=+1", ack - r);
        end
        req(1'b1, 32'h8000_0004, '0, rd, ack);
        n_cmp++;
        if (rd !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL unmapped_fifo status=%h want=00000002", rd);
        end
        req(1'b1, 32'h8000_0000, '0, rd, ack);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL uart_data_read got=%h want=00000000", rd);
        end
        for (int n = 0; n < 8; n++) begin
            if (n % 2 == 0) a = {1'b0, 31'($urandom_range(RW, 32'h1FFF_FFFF)) << 2};
            else            a = {1'b1, 31'($urandom_range(2, 32'h1FFF_FFFF)) << 2};
            req(1'b0, a, $urandom, rd, ack);
            r = cyc;
            req(1'b1, a, '0, rd, ack);
            n_cmp++;
            if (ack != r + 1 || rd !== 32'h0) begin
                n_err++;
                $display("FAIL unmapped_rand addr=%h got=%h@+%0d want=00000000@+1", a, rd, ack - r);
            end
        end
        req(1'b1, 32'h0000_0010, '0, rd, ack);
        n_cmp++;
        if (rd !== ram_m[4]) begin
            n_err++;
            $display("FAIL unmapped_ram got=%h want=%h", rd, ram_m[4]);
        end
    endtask

    // Compare every recorded frame of the model against the serial history
    task automatic check_frames();
        int         s;
        logic       bad, e;
        logic [9:0] exp_pat, act_pat;
        foreach (m_pop[i]) begin
            s       = m_pop[i] + 1;
            exp_pat = {1'b1, m_byte[i], 1'b0};
            bad     = (tx_hist[s - 1] !== 1'b1);
            for (int c = 0; c < FRAME; c++) begin
                e = exp_pat[c / CPB];
                if (tx_hist[s + c] !== e) bad = 1'b1;
            end
            for (int k = 0; k < 10; k++) act_pat[k] = tx_hist[s + k * CPB + CPB / 2];
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL frame%0d start=%0d got=%b want=%b (stop..start)", i, s, act_pat, exp_pat);
            end
        end
        clear_model();
    endtask

    task automatic test_uart_frame();
        logic [31:0] rd;
        int          ea, ack, r;
        r = cyc;
        uart_write(8'h55, ea, ack);
        n_cmp++;
        if (ack != ea || ea != r + 1) begin
            n_err++;
            $display("FAIL uart_write_accept got=%0d want=%0d", ack, ea);
        end
        req(1'b1, 32'h8000_0004, '0, rd, ack);
        n_cmp++;
        if (rd !== status_at(ack) || rd !== 32'h0000_0006) begin
            n_err++;
            $display("FAIL status_midframe got=%h want=%h", rd, status_at(ack));
        end
        wait_uart_done();
        check_frames();
    endtask

    task automatic test_fifo_full();
        int ea, ack;
        for (int n = 0; n < 6; n++) begin
            uart_write(8'(8'h41 + n), ea, ack);
            n_cmp++;
            if (ack != ea) begin
                n_err++;
                $display("FAIL fifo_full_accept%0d got=%0d want=%0d", n, ack, ea);
            end
        end
        wait_uart_done();
        check_frames();
    endtask

    task automatic test_uart_random();
        logic [31:0] rd;
        int          ea, ack;
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                req(1'b1, 32'h8000_0004, '0, rd, ack);
                n_cmp++;
                if (rd !== status_at(ack)) begin
                    n_err++;
                    $display("FAIL status_rand got=%h want=%h", rd, status_at(ack));
                end
            end else begin
                uart_write(8'($urandom), ea, ack);
                n_cmp++;
                if (ack != ea) begin
                    n_err++;
                    $display("FAIL uart_rand_accept got=%0d want=%0d", ack, ea);
                end
            end
            idle(int'($urandom_range(0, 30)));
        end
        wait_uart_done();
        check_frames();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd, d;
        logic [7:0]  b0;
        int          ea, ack, t0;
        logic        bad;
        d = $urandom;
        req(1'b0, 32'h0000_0020, d, rd, ack);
        ram_m[8] = d;
        b0 = 8'($urandom) & 8'hF7;
        uart_write(b0, ea, ack);
        uart_write(8'($urandom), ea, ack);
        uart_write(8'($urandom), ea, ack);
        // one cycle into data bit 3 of the first frame
        t0 = m_pop[0] + 1 + 4 * CPB + 1;
        while (cyc < t0) idle(1);
        n_cmp++;
        if (o_tx !== b0[3]) begin
            n_err++;
            $display("FAIL pre_reset_bit3 got=%b want=%b", o_tx, b0[3]);
        end
        i_rst = 1'b1;
        idle(1);
        i_rst = 1'b0;
        n_cmp++;
        if (o_tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_line_high got=%b want=1", o_tx);
        end
        clear_model();
        t0 = cyc;
        req(1'b1, 32'h8000_0004, '0, rd, ack);
        n_cmp++;
        if (rd !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL reset_status got=%h want=00000002", rd);
        end
        req(1'b1, 32'h0000_0020, '0, rd, ack);
        n_cmp++;
        if (rd !== d) begin
            n_err++;
            $display("FAIL ram_after_reset got=%h want=%h", rd, d);
        end
        idle(3 * FRAME);
        bad = 1'b0;
        for (int c = t0; c < cyc; c++) if (tx_hist[c] !== 1'b1) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL queued_bytes_dropped got=activity want=line_high");
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_ram_random();
        test_unmapped();
        test_uart_frame();
        test_fifo_full();
        test_uart_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
